// File: rtl/fft_int2fp_pkg.sv
// Shared constants and helpers for the int-to-float round-robin dispatcher.
package fft_int2fp_pkg;

    localparam int NUM_CH_DEF = 4;
    localparam int DATA_W_DEF = 32;

    // Pointer width for a ring of n channels; never narrower than one bit.
    function automatic int ptr_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/fft_int2fp_ch_slot.sv
// One channel slot: tracks an outstanding core operation and buffers its
// result until the collector pops it, so results are never overwritten.
module fft_int2fp_ch_slot
    import fft_int2fp_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              issue,
    input  logic              done,
    input  logic              pop,
    input  logic [DATA_W-1:0] result,
    output logic              pend,
    output logic              hold_v,
    output logic [DATA_W-1:0] hold_d,
    output logic              stray_done
);

    logic capture;

    assign capture    = done & pend;
    assign stray_done = done & ~pend;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pend   <= 1'b0;
            hold_v <= 1'b0;
            hold_d <= '0;
        end else begin
            if (issue) begin
                pend <= 1'b1;
            end else if (capture) begin
                pend <= 1'b0;
            end
            // Issue is gated by ~hold_v upstream, so capture and pop never collide.
            if (capture) begin
                hold_v <= 1'b1;
                hold_d <= result;
            end else if (pop) begin
                hold_v <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/fft_int2fp_rr_dispatch.sv
// Round-robin dispatcher feeding NUM_CH int-to-float cores and reassembling
// results in input order. Optional perf counters: FFT_INT2FP_PERF_CNT_EN.
module fft_int2fp_rr_dispatch
    import fft_int2fp_pkg::*;
#(
    parameter int NUM_CH = NUM_CH_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic                     s_axi_aclk,
    input  logic                     s_axi_areset,
    input  logic [DATA_W-1:0]        in_data,
    input  logic                     in_valid,
    output logic                     in_ready,
    output logic [DATA_W-1:0]        out_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [NUM_CH-1:0]        ap_start,
    input  logic [NUM_CH-1:0]        ap_idle,
    input  logic [NUM_CH-1:0]        ap_done,
    output logic [NUM_CH*DATA_W-1:0] core_in,
    input  logic [NUM_CH*DATA_W-1:0] core_out,
    output logic                     proto_err
`ifdef FFT_INT2FP_PERF_CNT_EN
    ,
    input  logic                     perf_clr,
    output logic [31:0]              perf_in,
    output logic [31:0]              perf_out,
    output logic [31:0]              perf_stall
`endif
);

    localparam int PW = ptr_w(NUM_CH);

    logic [PW-1:0]     iss_ptr;
    logic [PW-1:0]     col_ptr;
    logic [NUM_CH-1:0] pend;
    logic [NUM_CH-1:0] hold_v;
    logic [NUM_CH-1:0] stray;
    logic [NUM_CH-1:0] issue;
    logic [NUM_CH-1:0] pop;
    logic [DATA_W-1:0] hold_d [NUM_CH];
    logic              accept;
    logic              xfer;

    assign in_ready  = ap_idle[iss_ptr] & ~pend[iss_ptr] & ~hold_v[iss_ptr];
    assign accept    = in_valid & in_ready;
    assign out_valid = hold_v[col_ptr];
    assign out_data  = hold_d[col_ptr];
    assign xfer      = out_valid & out_ready;

    for (genvar c = 0; c < NUM_CH; c++) begin : g_slot
        assign issue[c] = accept & (iss_ptr == PW'(c));
        assign pop[c]   = xfer & (col_ptr == PW'(c));

        fft_int2fp_ch_slot #(
            .DATA_W(DATA_W)
        ) u_slot (
            .clk       (s_axi_aclk),
            .rst       (s_axi_areset),
            .issue     (issue[c]),
            .done      (ap_done[c]),
            .pop       (pop[c]),
            .result    (core_out[c*DATA_W +: DATA_W]),
            .pend      (pend[c]),
            .hold_v    (hold_v[c]),
            .hold_d    (hold_d[c]),
            .stray_done(stray[c])
        );
    end

    always_ff @(posedge s_axi_aclk or posedge s_axi_areset) begin
        if (s_axi_areset) begin
            iss_ptr   <= '0;
            col_ptr   <= '0;
            ap_start  <= '0;
            core_in   <= '0;
            proto_err <= 1'b0;
        end else begin
            // The start pulse follows the operand register by construction.
            ap_start <= issue;
            for (int c = 0; c < NUM_CH; c++) begin
                if (issue[c]) begin
                    core_in[c*DATA_W +: DATA_W] <= in_data;
                end
            end
            if (accept) begin
                iss_ptr <= (iss_ptr == PW'(NUM_CH-1)) ? '0 : iss_ptr + 1'b1;
            end
            if (xfer) begin
                col_ptr <= (col_ptr == PW'(NUM_CH-1)) ? '0 : col_ptr + 1'b1;
            end
            if (|stray) begin
                proto_err <= 1'b1;
            end
        end
    end

`ifdef FFT_INT2FP_PERF_CNT_EN
    always_ff @(posedge s_axi_aclk or posedge s_axi_areset) begin
        if (s_axi_areset) begin
            perf_in    <= '0;
            perf_out   <= '0;
            perf_stall <= '0;
        end else if (perf_clr) begin
            perf_in    <= '0;
            perf_out   <= '0;
            perf_stall <= '0;
        end else begin
            if (accept) begin
                perf_in <= perf_in + 32'd1;
            end
            if (xfer) begin
                perf_out <= perf_out + 32'd1;
            end
            if (in_valid & ~in_ready) begin
                perf_stall <= perf_stall + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_fft_int2fp_rr_dispatch.sv
// Bench for the round-robin int-to-float dispatcher: behavioural core models,
// in-order scoreboard, and scenario tasks. Perf checks under FFT_INT2FP_PERF_CNT_EN.
module tb_fft_int2fp_rr_dispatch;

    localparam int NUM_CH = 4;
    localparam int DATA_W = 32;

    logic                     clk = 1'b0;
    logic                     rst = 1'b1;
    logic [DATA_W-1:0]        in_data = '0;
    logic                     in_valid = 1'b0;
    logic                     in_ready;
    logic [DATA_W-1:0]        out_data;
    logic                     out_valid;
    logic                     out_ready = 1'b0;
    logic [NUM_CH-1:0]        ap_start;
    logic [NUM_CH-1:0]        ap_idle;
    logic [NUM_CH-1:0]        ap_done;
    logic [NUM_CH*DATA_W-1:0] core_in;
    logic [NUM_CH*DATA_W-1:0] core_out;
    logic                     proto_err;
`ifdef FFT_INT2FP_PERF_CNT_EN
    logic                     perf_clr = 1'b0;
    logic [31:0]              perf_in;
    logic [31:0]              perf_out;
    logic [31:0]              perf_stall;
`endif

    always #5 clk = ~clk;

    fft_int2fp_rr_dispatch #(
        .NUM_CH(NUM_CH),
        .DATA_W(DATA_W)
    ) dut (
        .s_axi_aclk  (clk),
        .s_axi_areset(rst),
        .in_data     (in_data),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .out_data    (out_data),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .ap_start    (ap_start),
        .ap_idle     (ap_idle),
        .ap_done     (ap_done),
        .core_in     (core_in),
        .core_out    (core_out),
        .proto_err   (proto_err)
`ifdef FFT_INT2FP_PERF_CNT_EN
        ,
        .perf_clr    (perf_clr),
        .perf_in     (perf_in),
        .perf_out    (perf_out),
        .perf_stall  (perf_stall)
`endif
    );

    int vectors = 0;
    int miscompares = 0;

    // Stand-in for the int-to-float core; the dispatcher only routes data.
    function automatic logic [DATA_W-1:0] conv(input logic [DATA_W-1:0] x);
        return {x[7:0], x[31:8]} ^ 32'h3f80_0000;
    endfunction

    // Core models: start seen one edge after accept, done pulse L cycles later.
    int                       lat [NUM_CH];
    int                       cnt [NUM_CH];
    logic [DATA_W-1:0]        opnd [NUM_CH];
    logic [NUM_CH-1:0]        core_busy = '0;
    logic [NUM_CH-1:0]        core_done_m = '0;
    logic [NUM_CH-1:0]        idle_force_low = '0;
    logic [NUM_CH-1:0]        inj_done = '0;
    logic [NUM_CH*DATA_W-1:0] core_out_m = '0;

    assign ap_idle  = ~core_busy & ~idle_force_low;
    assign ap_done  = core_done_m | inj_done;
    assign core_out = core_out_m;

    always begin
        @(posedge clk);
        #1;
        core_done_m = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            core_out_m[c*DATA_W +: DATA_W] = $urandom;
            if (core_busy[c]) begin
                cnt[c] = cnt[c] - 1;
                if (cnt[c] == 0) begin
                    core_done_m[c] = 1'b1;
                    core_out_m[c*DATA_W +: DATA_W] = conv(opnd[c]);
                    core_busy[c] = 1'b0;
                end
            end
        end
        for (int c = 0; c < NUM_CH; c++) begin
            if (ap_start[c]) begin
                core_busy[c] = 1'b1;
                cnt[c]       = lat[c] + 1;
                opnd[c]      = core_in[c*DATA_W +: DATA_W];
            end
        end
    end

    logic [DATA_W-1:0] exp_q [$];
    int first_acc_cyc;
    int first_out_cyc;
    int stall_cnt;

    task automatic set_lat(input int l0, input int l1, input int l2, input int l3);
        lat[0] = l0; lat[1] = l1; lat[2] = l2; lat[3] = l3;
    endtask

    // Streams n samples and drains everything queued, scoring output order.
    task automatic run(input int n, input int rdy_pct, input bit seq_data, input int budget);
        int sent = 0;
        int c = 0;
        logic [DATA_W-1:0] d;
        logic [DATA_W-1:0] exp;
        d = seq_data ? '0 : DATA_W'($urandom);
        first_acc_cyc = -1;
        first_out_cyc = -1;
        stall_cnt = 0;
        while ((sent < n || exp_q.size() != 0) && c < budget) begin
            @(posedge clk);
            #1;
            c++;
            in_valid  = (sent < n);
            in_data   = d;
            out_ready = ($urandom_range(99) < rdy_pct);
            @(negedge clk);
            if (in_valid && !in_ready && sent > 0) stall_cnt++;
            if (out_valid && first_out_cyc < 0) first_out_cyc = c;
            if (out_valid && out_ready) begin
                vectors++;
                if (exp_q.size() == 0) begin
                    miscompares++;
                    $display("FAIL out_extra: got %h with nothing outstanding", out_data);
                end else begin
                    exp = exp_q.pop_front();
                    if (out_data !== exp) begin
                        miscompares++;
                        $display("FAIL out_order: got %h expected %h", out_data, exp);
                    end
                end
            end
            if (in_valid && in_ready) begin
                exp_q.push_back(conv(d));
                if (sent == 0) first_acc_cyc = c;
                sent++;
                d = seq_data ? DATA_W'(sent) : DATA_W'($urandom);
            end
        end
        @(posedge clk);
        #1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        vectors++;
        if (sent != n || exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL run_budget: sent %0d of %0d, %0d still outstanding", sent, n, exp_q.size());
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle_force_low = '0;
        #3;
        vectors++;
        if (in_ready !== 1'b1) begin miscompares++; $display("FAIL rst_in_ready: got %b expected 1", in_ready); end
        vectors++;
        if (out_valid !== 1'b0) begin miscompares++; $display("FAIL rst_out_valid: got %b expected 0", out_valid); end
        vectors++;
        if (ap_start !== '0 || core_in !== '0) begin miscompares++; $display("FAIL rst_core: ap_start %b core_in %h expected 0", ap_start, core_in); end
        vectors++;
        if (proto_err !== 1'b0) begin miscompares++; $display("FAIL rst_proto_err: got %b expected 0", proto_err); end
        idle_force_low = 4'b0001;
        #1;
        vectors++;
        if (in_ready !== 1'b0) begin miscompares++; $display("FAIL rst_idle0_low: got %b expected 0", in_ready); end
        idle_force_low = 4'b0010;
        #1;
        vectors++;
        if (in_ready !== 1'b1) begin miscompares++; $display("FAIL rst_idle1_low: got %b expected 1", in_ready); end
        idle_force_low = '0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic test_stream_latency();
        set_lat(3, 3, 3, 3);
        run(16, 100, 1'b1, 200);
        vectors++;
        if (first_out_cyc - first_acc_cyc != 6) begin
            miscompares++;
            $display("FAIL first_latency: got %0d cycles expected 6", first_out_cyc - first_acc_cyc);
        end
    endtask

    task automatic test_throughput();
        set_lat(0, 0, 0, 0);
        run(16, 100, 1'b0, 200);
        vectors++;
        if (stall_cnt != 0) begin miscompares++; $display("FAIL throughput: %0d stall cycles expected 0", stall_cnt); end
    endtask

    task automatic test_backpressure();
        int acc = 0;
        logic [DATA_W-1:0] d;
        set_lat(3, 3, 3, 3);
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            #1;
            d = $urandom;
            in_valid  = 1'b1;
            in_data   = d;
            out_ready = 1'b0;
            @(negedge clk);
            if (in_ready) begin acc++; exp_q.push_back(conv(d)); end
        end
        vectors++;
        if (acc != 4) begin miscompares++; $display("FAIL bp_accepts: got %0d expected 4", acc); end
        vectors++;
        if (in_ready !== 1'b0 || out_valid !== 1'b1) begin
            miscompares++;
            $display("FAIL bp_stalled: in_ready %b out_valid %b expected 0/1", in_ready, out_valid);
        end
        run(8, 100, 1'b0, 200);
    endtask

    task automatic test_mixed_latency();
        set_lat(5, 2, 7, 1);
        run(40, 60, 1'b0, 2000);
    endtask

    task automatic test_proto_err();
        set_lat(2, 2, 2, 2);
        @(negedge clk);
        vectors++;
        if (proto_err !== 1'b0) begin miscompares++; $display("FAIL perr_pre: got %b expected 0", proto_err); end
        @(posedge clk);
        #1;
        inj_done = 4'b0100;
        @(posedge clk);
        #1;
        inj_done = '0;
        @(negedge clk);
        vectors++;
        if (proto_err !== 1'b1) begin miscompares++; $display("FAIL perr_set: got %b expected 1", proto_err); end
        run(8, 70, 1'b0, 400);
        vectors++;
        if (proto_err !== 1'b1) begin miscompares++; $display("FAIL perr_sticky: got %b expected 1", proto_err); end
    endtask

    task automatic test_reset_mid();
        int acc = 0;
        int c = 0;
        int spurious = 0;
        logic [DATA_W-1:0] d;
        set_lat(7, 7, 7, 7);
        while (acc < 3 && c < 50) begin
            @(posedge clk);
            #1;
            c++;
            in_valid  = 1'b1;
            in_data   = $urandom;
            out_ready = 1'b1;
            @(negedge clk);
            if (in_ready) acc++;
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        rst = 1'b1;
        #1;
        vectors++;
        if (out_valid !== 1'b0 || proto_err !== 1'b0) begin
            miscompares++;
            $display("FAIL mid_rst_out: out_valid %b proto_err %b expected 0/0", out_valid, proto_err);
        end
        vectors++;
        if (in_ready !== 1'b0 || ap_start !== '0) begin
            miscompares++;
            $display("FAIL mid_rst_ready: in_ready %b ap_start %b expected 0/0", in_ready, ap_start);
        end
        exp_q.delete();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (out_valid) spurious++;
        end
        vectors++;
        if (proto_err !== 1'b1 || spurious != 0) begin
            miscompares++;
            $display("FAIL mid_rst_late_done: proto_err %b out_valid cycles %0d expected 1/0", proto_err, spurious);
        end
        acc = 0;
        c = 0;
        d = $urandom;
        while (acc == 0 && c < 30) begin
            @(posedge clk);
            #1;
            c++;
            in_valid = 1'b1;
            in_data  = d;
            @(negedge clk);
            if (in_ready) begin acc = 1; exp_q.push_back(conv(d)); end
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(negedge clk);
        vectors++;
        if (ap_start !== 4'b0001) begin miscompares++; $display("FAIL mid_rst_ptr: ap_start %b expected 0001", ap_start); end
        run(4, 100, 1'b0, 200);
    endtask

`ifdef FFT_INT2FP_PERF_CNT_EN
    task automatic test_perf();
        set_lat(0, 0, 0, 0);
        @(posedge clk);
        #1;
        perf_clr = 1'b1;
        @(posedge clk);
        #1;
        perf_clr = 1'b0;
        idle_force_low = '1;
        in_valid = 1'b1;
        in_data  = $urandom;
        repeat (4) @(posedge clk);
        #1;
        in_valid = 1'b0;
        idle_force_low = '0;
        run(10, 100, 1'b0, 200);
        @(negedge clk);
        vectors++;
        if (perf_in !== 32'd10 || perf_stall !== 32'd4 || perf_out !== 32'd10) begin
            miscompares++;
            $display("FAIL perf_counts: in %0d out %0d stall %0d expected 10/10/4", perf_in, perf_out, perf_stall);
        end
        @(posedge clk);
        #1;
        perf_clr = 1'b1;
        @(posedge clk);
        #1;
        perf_clr = 1'b0;
        vectors++;
        if (perf_in !== '0 || perf_out !== '0 || perf_stall !== '0) begin
            miscompares++;
            $display("FAIL perf_clr: in %0d out %0d stall %0d expected 0", perf_in, perf_out, perf_stall);
        end
    endtask
`endif

    initial begin
        set_lat(0, 0, 0, 0);
        test_reset();
        test_stream_latency();
        test_throughput();
        test_backpressure();
        test_mixed_latency();
        test_proto_err();
        test_reset_mid();
`ifdef FFT_INT2FP_PERF_CNT_EN
        test_perf();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

endmodule
